// File: rtl/w_alu_pkg.sv
// Shared opcode and FSM state types for the W-register ALU unit.
package w_alu_pkg;

  localparam int unsigned OPW            = 4;
  localparam int unsigned OP_ILLEGAL_MIN = 12;

  typedef enum logic [OPW-1:0] {
    OP_NOP  = 4'd0,
    OP_LOAD = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_ADC  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_MUL  = 4'd10,
    OP_CLR  = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } state_e;

endpackage

// File: rtl/w_alu_seqmul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Final product is presented combinationally alongside o_done_c on the last iteration edge.
module w_alu_seqmul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done_c,
  output logic [2*WIDTH-1:0]   o_prod_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mplier_nxt;
  logic             w_last;

  // Add multiplicand when the current multiplier LSB is set, then shift {acc,mplier} right.
  assign w_sum        = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_nxt    = w_sum[WIDTH:1];
  assign w_mplier_nxt = {w_sum[0], r_mplier[WIDTH-1:1]};
  assign w_last       = (r_cnt == CW'(WIDTH - 1));
  assign o_done_c     = r_busy & w_last;
  assign o_prod_c     = {w_acc_nxt, w_mplier_nxt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= i_a;
      r_acc    <= '0;
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/w_alu_unit.sv
// W/H register ALU with valid/ready intake; single-cycle ops, multi-cycle shifts and multiply.
// Architectural state (w, h, carry, zero) only moves on the retire edge of each op.
module w_alu_unit
  import w_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   inst,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] h,
  output logic             carry,
  output logic             zero,
  output logic             done,
  output logic             illegal
);

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_w, w_w_nxt;
  logic [WIDTH-1:0]   r_h, w_h_nxt;
  logic [WIDTH-1:0]   r_sh, w_sh_nxt;
  logic [CNTW-1:0]    r_cnt, w_cnt_nxt;
  logic               r_dir, w_dir_nxt;
  logic               r_carry, w_carry_nxt;
  logic               r_zero, w_zero_nxt;
  logic               r_done, w_done_nxt;
  logic               r_illegal, w_illegal_nxt;
  logic               r_ready, w_ready_nxt;
  logic               w_retire;

  logic [CNTW-1:0]    w_n;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_adc;
  logic [WIDTH-1:0]   w_sh_step;
  logic               w_sh_out;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  assign w_n       = b[CNTW-1:0];
  assign w_add     = {1'b0, r_w} + {1'b0, b};
  assign w_adc     = w_add + (WIDTH+1)'(r_carry);
  // r_dir: 0 = left, 1 = right
  assign w_sh_step = r_dir ? (r_sh >> 1) : (r_sh << 1);
  assign w_sh_out  = r_dir ? r_sh[0] : r_sh[WIDTH-1];

  w_alu_seqmul #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst_n    (reset),
    .i_start  (w_mul_start),
    .i_a      (r_w),
    .i_b      (b),
    .o_done_c (w_mul_done),
    .o_prod_c (w_mul_prod)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_w_nxt       = r_w;
    w_h_nxt       = r_h;
    w_sh_nxt      = r_sh;
    w_cnt_nxt     = r_cnt;
    w_dir_nxt     = r_dir;
    w_carry_nxt   = r_carry;
    w_zero_nxt    = r_zero;
    w_done_nxt    = 1'b0;
    w_illegal_nxt = 1'b0;
    w_retire      = 1'b0;
    w_mul_start   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_retire      = 1'b1;
          w_illegal_nxt = (inst >= OPW'(OP_ILLEGAL_MIN));
          case (op_e'(inst))
            OP_LOAD: begin w_w_nxt = b; w_h_nxt = '0; w_carry_nxt = 1'b0; end
            OP_ADD:  {w_carry_nxt, w_w_nxt} = w_add;
            OP_SUB:  begin w_w_nxt = r_w - b; w_carry_nxt = (r_w < b); end
            OP_ADC:  {w_carry_nxt, w_w_nxt} = w_adc;
            OP_AND:  w_w_nxt = r_w & b;
            OP_OR:   w_w_nxt = r_w | b;
            OP_XOR:  w_w_nxt = r_w ^ b;
            OP_SHL, OP_SHR: begin
              if (w_n == '0) begin
                w_carry_nxt = 1'b0;
              end else begin
                w_retire    = 1'b0;
                w_state_nxt = SHIFT;
                w_sh_nxt    = r_w;
                w_cnt_nxt   = w_n;
                w_dir_nxt   = (inst == OP_SHR);
              end
            end
            OP_MUL: begin
              w_retire    = 1'b0;
              w_mul_start = 1'b1;
              w_state_nxt = MUL;
            end
            OP_CLR:  begin w_w_nxt = '0; w_h_nxt = '0; w_carry_nxt = 1'b0; end
            default: ;
          endcase
        end
      end
      SHIFT: begin
        w_sh_nxt  = w_sh_step;
        w_cnt_nxt = r_cnt - CNTW'(1);
        if (r_cnt == CNTW'(1)) begin
          w_retire    = 1'b1;
          w_w_nxt     = w_sh_step;
          w_carry_nxt = w_sh_out;
          w_state_nxt = IDLE;
        end
      end
      MUL: begin
        if (w_mul_done) begin
          w_retire    = 1'b1;
          w_w_nxt     = w_mul_prod[WIDTH-1:0];
          w_h_nxt     = w_mul_prod[2*WIDTH-1:WIDTH];
          w_carry_nxt = |w_mul_prod[2*WIDTH-1:WIDTH];
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_retire) begin
      w_done_nxt = 1'b1;
      w_zero_nxt = (w_w_nxt == '0);
    end
    w_ready_nxt = (w_state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_w       <= '0;
      r_h       <= '0;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_dir     <= 1'b0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b1;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_w       <= w_w_nxt;
      r_h       <= w_h_nxt;
      r_sh      <= w_sh_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dir     <= w_dir_nxt;
      r_carry   <= w_carry_nxt;
      r_zero    <= w_zero_nxt;
      r_done    <= w_done_nxt;
      r_illegal <= w_illegal_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign in_ready = r_ready;
  assign w        = r_w;
  assign h        = r_h;
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign done     = r_done;
  assign illegal  = r_illegal;

endmodule
